// File: rtl/spu_sched_pkg.sv
// Shared types and helpers for the SPU ALU scheduler: FSM state encoding,
// opcode width and requester-ID width function.
package spu_sched_pkg;

   localparam int unsigned OPC_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_e;

   // Width of a requester ID; never below one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spu_rr_arbiter.sv
// Combinational round-robin arbiter: rotate by pointer, pick lowest set bit,
// rotate back. Produces a one-hot grant and the encoded winner ID.
module spu_rr_arbiter
   import spu_sched_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned ID_W = id_width(N)
)(
   input  logic [N-1:0]    i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic [N-1:0]    o_grant,
   output logic [ID_W-1:0] o_id
);

   logic [2*N-1:0]  w_dbl;
   logic [N-1:0]    w_rot;
   logic [ID_W-1:0] w_off;

   always_comb begin
      w_dbl = {i_req, i_req} >> i_ptr;
      w_rot = w_dbl[N-1:0];
      w_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = ID_W'(i);
      end
      // N is a power of two, so the ID add wraps naturally.
      o_id    = w_off + i_ptr;
      o_grant = (|i_req) ? (N'(1) << o_id) : '0;
   end

endmodule

// File: rtl/spu_alu_scheduler.sv
// Arbitrates NUM_REQ requesters onto one multi-cycle ALU with watchdog and
// thermal cool-down. Optional fixed priority for requester 0: SPU_SCHED_BINDU_PRIO_EN.
module spu_alu_scheduler
   import spu_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned TIMEOUT      = 64,
   parameter int unsigned THROTTLE_GAP = 8
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*OPC_W-1:0]       req_opcode,
   input  logic [NUM_REQ*WIDTH-1:0]       req_a,
   input  logic [NUM_REQ*WIDTH-1:0]       req_b,
   output logic                           alu_start,
   output logic [OPC_W-1:0]               alu_opcode,
   output logic [WIDTH-1:0]               alu_a,
   output logic [WIDTH-1:0]               alu_b,
   input  logic [2*WIDTH-1:0]             alu_result,
   input  logic                           alu_valid,
   input  logic                           throttle,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [id_width(NUM_REQ)-1:0]   rsp_id,
   output logic [2*WIDTH-1:0]             rsp_data,
   output logic                           rsp_err,
   output logic                           busy
);

   localparam int unsigned ID_W = id_width(NUM_REQ);
   localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
   localparam int unsigned CD_W = $clog2(THROTTLE_GAP + 1);

   sched_state_e       r_state;
   logic [ID_W-1:0]    r_ptr;
   logic [ID_W-1:0]    r_id;
   logic [CD_W-1:0]    r_cool;
   logic [WD_W-1:0]    r_wdog;
   logic               r_alu_start;
   logic [OPC_W-1:0]   r_alu_opcode;
   logic [WIDTH-1:0]   r_alu_a;
   logic [WIDTH-1:0]   r_alu_b;
   logic               r_rsp_valid;
   logic [ID_W-1:0]    r_rsp_id;
   logic [2*WIDTH-1:0] r_rsp_data;
   logic               r_rsp_err;
   logic               r_busy;

   logic [NUM_REQ-1:0] w_arb_req;
   logic [NUM_REQ-1:0] w_rr_grant;
   logic [ID_W-1:0]    w_rr_id;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_id;
   logic               w_ptr_upd;
   logic               w_accept;
   logic [OPC_W-1:0]   w_opc;
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic [WD_W-1:0]    w_wdog_nxt;

   spu_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
      .i_req   (w_arb_req),
      .i_ptr   (r_ptr),
      .o_grant (w_rr_grant),
      .o_id    (w_rr_id)
   );

`ifdef SPU_SCHED_BINDU_PRIO_EN
   // Requester 0 bypasses the rotation; only grants to others advance the pointer.
   assign w_arb_req = req_valid & ~NUM_REQ'(1);
   assign w_grant   = req_valid[0] ? NUM_REQ'(1) : w_rr_grant;
   assign w_id      = req_valid[0] ? '0 : w_rr_id;
   assign w_ptr_upd = (r_rsp_id != '0);
`else
   assign w_arb_req = req_valid;
   assign w_grant   = w_rr_grant;
   assign w_id      = w_rr_id;
   assign w_ptr_upd = 1'b1;
`endif

   assign req_ready  = (rst_n && (r_state == ST_IDLE) && (r_cool == '0)) ? w_grant : '0;
   assign w_accept   = |req_ready;
   assign w_wdog_nxt = r_wdog + WD_W'(1);

   // Select the winner's payload from the packed request buses.
   always_comb begin
      w_opc = '0;
      w_a   = '0;
      w_b   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_id == ID_W'(i)) begin
            w_opc = req_opcode[i*OPC_W +: OPC_W];
            w_a   = req_a[i*WIDTH +: WIDTH];
            w_b   = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_id         <= '0;
         r_cool       <= '0;
         r_wdog       <= '0;
         r_alu_start  <= 1'b0;
         r_alu_opcode <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_alu_start <= 1'b0;
         if (r_cool != '0) r_cool <= r_cool - CD_W'(1);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_alu_start  <= 1'b1;
                  r_alu_opcode <= w_opc;
                  r_alu_a      <= w_a;
                  r_alu_b      <= w_b;
                  r_id         <= w_id;
                  r_busy       <= 1'b1;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_wdog  <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A result arriving on the timeout cycle still wins.
               if (alu_valid) begin
                  r_rsp_data  <= alu_result;
                  r_rsp_err   <= 1'b0;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (w_wdog_nxt == WD_W'(TIMEOUT - 1)) begin
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_wdog <= w_wdog_nxt;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
                  r_cool      <= throttle ? CD_W'(THROTTLE_GAP) : '0;
                  if (w_ptr_upd) r_ptr <= r_rsp_id + ID_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign alu_start  = r_alu_start;
   assign alu_opcode = r_alu_opcode;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_spu_alu_scheduler.sv
// Directed self-checking bench for spu_alu_scheduler (default parameters).
module tb_spu_alu_scheduler;

   localparam int unsigned NR = 4;
   localparam int unsigned W  = 32;
   localparam int unsigned TO = 64;
   localparam int unsigned TG = 8;

   logic            clk;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*4-1:0] req_opcode;
   logic [NR*W-1:0] req_a;
   logic [NR*W-1:0] req_b;
   logic            alu_start;
   logic [3:0]      alu_opcode;
   logic [W-1:0]    alu_a;
   logic [W-1:0]    alu_b;
   logic [2*W-1:0]  alu_result;
   logic            alu_valid;
   logic            throttle;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [2*W-1:0]  rsp_data;
   logic            rsp_err;
   logic            busy;

   int n_chk;
   int n_err;
   int cyc;

   spu_alu_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO), .THROTTLE_GAP(TG)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b),
      .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_valid(alu_valid), .throttle(throttle),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_slot(input int i, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
      req_opcode[i*4 +: 4] = op;
      req_a[i*W +: W]      = a;
      req_b[i*W +: W]      = b;
   endtask

   // Waits (bounded) for a non-zero req_ready; leaves time inside the grant cycle.
   task automatic wait_grant(output logic [NR-1:0] g, output int gcyc);
      g    = '0;
      gcyc = -100;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (req_ready != '0) begin
            g    = req_ready;
            gcyc = cyc;
            break;
         end
         tick();
      end
   endtask

   // From the grant cycle: issue, ALU answers lat cycles after alu_start, then handshake.
   task automatic finish_op(input int lat, input logic [2*W-1:0] res, input bit drop,
                            output int hcyc, output logic [1:0] rid,
                            output logic [2*W-1:0] rd, output logic [3:0] op);
      hcyc = -100;
      rid  = 'x;
      rd   = 'x;
      tick();
      if (drop) req_valid = '0;
      op = alu_opcode;
      repeat (lat) tick();
      alu_result = res;
      alu_valid  = 1'b1;
      tick();
      alu_valid  = 1'b0;
      alu_result = '0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (rsp_valid && rsp_ready) begin
            hcyc = cyc;
            rid  = rsp_id;
            rd   = rsp_data;
            tick();
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_chk++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL reset_alu_start got %b exp 0", alu_start); end
      n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      n_chk++; if ({alu_opcode, alu_a, alu_b} !== '0) begin n_err++; $display("FAIL reset_alu_fields got %h exp 0", {alu_opcode, alu_a, alu_b}); end
      n_chk++; if ({rsp_id, rsp_data, rsp_err} !== '0) begin n_err++; $display("FAIL reset_rsp_fields got %h exp 0", {rsp_id, rsp_data, rsp_err}); end
      n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int t0;
      set_slot(2, 4'd3, 32'd7, 32'd6);
      req_valid = 4'b0100;
      #1;
      t0 = cyc;
      n_chk++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_req_ready got %b exp 0100", req_ready); end
      tick();
      req_valid = '0;
      n_chk++; if (alu_start !== 1'b1) begin n_err++; $display("FAIL single_alu_start got %b exp 1", alu_start); end
      n_chk++; if ({alu_opcode, alu_a, alu_b} !== {4'd3, 32'd7, 32'd6}) begin n_err++; $display("FAIL single_alu_fields got %h exp %h", {alu_opcode, alu_a, alu_b}, {4'd3, 32'd7, 32'd6}); end
      n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", busy); end
      tick();
      n_chk++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse got %b exp 0", alu_start); end
      tick();
      tick();
      alu_result = 64'd42;
      alu_valid  = 1'b1;
      n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_early got %b exp 0", rsp_valid); end
      tick();
      alu_valid  = 1'b0;
      alu_result = '0;
      n_chk++; if (rsp_valid !== 1'b1 || cyc - t0 != 5) begin n_err++; $display("FAIL single_rsp_valid got %b at +%0d exp 1 at +5", rsp_valid, cyc - t0); end
      n_chk++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
      n_chk++; if (rsp_data !== 64'd42) begin n_err++; $display("FAIL single_rsp_data got %0d exp 42", rsp_data); end
      n_chk++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp_err got %b exp 0", rsp_err); end
      tick();
      n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle got valid %b busy %b exp 0 0", rsp_valid, busy); end
   endtask

   task automatic test_fairness();
      logic [NR-1:0] g;
      logic [NR-1:0] eg;
      logic [1:0]    rid;
      logic [1:0]    eid;
      logic [63:0]   rd;
      logic [3:0]    op;
      int            tg, tprev, hc;
      do_reset();
      for (int i = 0; i < 4; i++) set_slot(i, 4'(i + 1), 32'(10 * (i + 1)), 32'(i + 2));
      req_valid = 4'hF;
      tprev = 0;
      for (int n = 0; n < 8; n++) begin
`ifdef SPU_SCHED_BINDU_PRIO_EN
         eid = 2'd0;
`else
         eid = 2'(n % 4);
`endif
         eg = 4'b0001 << eid;
         wait_grant(g, tg);
         n_chk++; if (g !== eg) begin n_err++; $display("FAIL fair_grant[%0d] got %b exp %b", n, g, eg); end
         if (n > 0) begin
            n_chk++; if (tg - tprev != 4) begin n_err++; $display("FAIL fair_spacing[%0d] got %0d exp 4", n, tg - tprev); end
         end
         tprev = tg;
         finish_op(1, 64'(1000 + n), n == 7, hc, rid, rd, op);
         n_chk++; if (rid !== eid) begin n_err++; $display("FAIL fair_rsp_id[%0d] got %0d exp %0d", n, rid, eid); end
         n_chk++; if (rd !== 64'(1000 + n)) begin n_err++; $display("FAIL fair_rsp_data[%0d] got %0d exp %0d", n, rd, 1000 + n); end
         n_chk++; if (op !== 4'(eid + 1)) begin n_err++; $display("FAIL fair_opcode[%0d] got %0d exp %0d", n, op, eid + 1); end
      end
   endtask

   task automatic test_timeout();
      logic [NR-1:0] g;
      int            tg;
      bit            early;
      req_valid = 4'b0001;
      wait_grant(g, tg);
      n_chk++; if (g !== 4'b0001) begin n_err++; $display("FAIL to_grant got %b exp 0001", g); end
      tick();
      req_valid = '0;
      n_chk++; if (alu_start !== 1'b1) begin n_err++; $display("FAIL to_alu_start got %b exp 1", alu_start); end
      early = 1'b0;
      for (int j = 1; j < TO; j++) begin
         tick();
         if (rsp_valid !== 1'b0) early = 1'b1;
      end
      n_chk++; if (early !== 1'b0) begin n_err++; $display("FAIL to_early_rsp got %b exp 0", early); end
      tick();
      n_chk++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL to_rsp_valid got %b exp 1", rsp_valid); end
      n_chk++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL to_rsp_err got %b exp 1", rsp_err); end
      n_chk++; if (rsp_data !== 64'd0) begin n_err++; $display("FAIL to_rsp_data got %h exp 0", rsp_data); end
      n_chk++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL to_rsp_id got %0d exp 0", rsp_id); end
      tick();
      alu_result = 64'd99;
      alu_valid  = 1'b1;
      tick();
      alu_valid  = 1'b0;
      alu_result = '0;
      n_chk++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_start !== 1'b0) begin n_err++; $display("FAIL to_late_ignored got busy %b valid %b start %b exp 0 0 0", busy, rsp_valid, alu_start); end
      tick();
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_late_busy got %b exp 0", busy); end
   endtask

   task automatic test_throttle();
      logic [NR-1:0] g;
      logic [1:0]    rid;
      logic [63:0]   rd;
      logic [3:0]    op;
      int            tg, h1, h2;
      throttle  = 1'b1;
      req_valid = 4'b0010;
      wait_grant(g, tg);
      n_chk++; if (g !== 4'b0010) begin n_err++; $display("FAIL thr_grant1 got %b exp 0010", g); end
      finish_op(1, 64'd5, 1'b0, h1, rid, rd, op);
      wait_grant(g, tg);
      n_chk++; if (tg - h1 != TG + 1) begin n_err++; $display("FAIL thr_gap_on got %0d exp %0d", tg - h1, TG + 1); end
      throttle = 1'b0;
      finish_op(1, 64'd6, 1'b0, h2, rid, rd, op);
      wait_grant(g, tg);
      n_chk++; if (tg - h2 != 1) begin n_err++; $display("FAIL thr_gap_off got %0d exp 1", tg - h2); end
      finish_op(1, 64'd7, 1'b1, h2, rid, rd, op);
      n_chk++; if (rd !== 64'd7) begin n_err++; $display("FAIL thr_rsp_data got %0d exp 7", rd); end
   endtask

   task automatic test_backpressure_reset();
      logic [NR-1:0] g;
      logic [NR-1:0] eg;
      int            tg;
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      wait_grant(g, tg);
      n_chk++; if (g !== 4'b0100) begin n_err++; $display("FAIL bp_grant got %b exp 0100", g); end
      tick();
      req_valid = 4'b1011;
      tick();
      alu_result = 64'h1234_5678_9abc_def0;
      alu_valid  = 1'b1;
      tick();
      alu_result = 64'h0000_0000_dead_beef;
      for (int j = 0; j < 10; j++) begin
         if (j == 1) alu_valid = 1'b0;
         n_chk++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 64'h1234_5678_9abc_def0 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold[%0d] got v%b id%0d d%h e%b exp v1 id2 d123456789abcdef0 e0", j, rsp_valid, rsp_id, rsp_data, rsp_err);
         end
         n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_accept[%0d] got %b exp 0000", j, req_ready); end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      tick();
      #1;
`ifdef SPU_SCHED_BINDU_PRIO_EN
      eg = 4'b0001;
`else
      eg = 4'b1000;
`endif
      n_chk++; if (req_ready !== eg) begin n_err++; $display("FAIL bp_next_grant got %b exp %b", req_ready, eg); end
      tick();
      tick();
      n_chk++; if (busy !== 1'b1 || alu_start !== 1'b0) begin n_err++; $display("FAIL rst_in_wait got busy %b start %b exp 1 0", busy, alu_start); end
      rst_n = 1'b0;
      #1;
      n_chk++; if ({busy, alu_start, rsp_valid, rsp_err} !== 4'b0000) begin n_err++; $display("FAIL rst_ctrl got %b exp 0000", {busy, alu_start, rsp_valid, rsp_err}); end
      n_chk++; if ({alu_opcode, alu_a, alu_b, rsp_id, rsp_data} !== '0) begin n_err++; $display("FAIL rst_data got %h exp 0", {alu_opcode, alu_a, alu_b, rsp_id, rsp_data}); end
      n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
      tick();
      rst_n = 1'b1;
      #1;
      n_chk++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant got %b exp 0001", req_ready); end
      tick();
      req_valid = '0;
      tick();
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      cyc        = 0;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      alu_result = '0;
      alu_valid  = 1'b0;
      throttle   = 1'b0;
      rsp_ready  = 1'b1;
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_throttle();
      test_backpressure_reset();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1);
   end

endmodule

// File: doc/spu_alu_scheduler.md
Name: spu_alu_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle Vedic ALU among NUM_REQ requesters (NoC clusters, IO path, cache fill logic).
- Accepts one request at a time, issues it to the ALU and waits for the result. A watchdog bounds the wait.
- Returns the result tagged with the requester ID.
- Honours the thermal throttle by inserting cool-down gaps between operations.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- WIDTH, 32, operand width.
- TIMEOUT, 64, maximum WAIT cycles before an error response; at least 2.
- THROTTLE_GAP, 8, idle cycles enforced after each response while throttle=1; at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_opcode  in  NUM_REQ*4  packed opcodes; requester i occupies bits [4i+3:4i].
- req_a  in  NUM_REQ*WIDTH  packed operand A.
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- alu_start  out  1  one-cycle issue pulse.
- alu_opcode  out  4  latched opcode.
- alu_a  out  WIDTH  latched operand A.
- alu_b  out  WIDTH  latched operand B.
- alu_result  in  2*WIDTH  ALU result.
- alu_valid  in  1  ALU result strobe.
- throttle  in  1  thermal throttle for this ALU's zone.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  log2(NUM_REQ)  ID of the requester that owns the response.
- rsp_data  out  2*WIDTH  result.
- rsp_err  out  1  timeout flag.
- busy  out  1  state other than IDLE.

Behaviour:
- Reset: all outputs 0; RR pointer = 0; cool-down counter = 0; state = IDLE.

IDLE state:
- Arbitrate when the cool-down counter = 0 and any req_valid bit is set.
- Winner is the first set req_valid bit scanning from the RR pointer upward, with wrap.
- In the same cycle: req_ready[winner] = 1 (combinational, only when req_valid[winner] = 1); latch opcode, a, b and id; move to ISSUE.
- A request completes its handshake on the cycle req_valid & req_ready are both 1.
- Requesters must hold their fields stable while req_valid is high and req_ready is low.

ISSUE state (one cycle):
- alu_start = 1.
- alu_opcode, alu_a, alu_b are driven from the latches. They stay stable until the next accept.
- Watchdog is cleared. Move to WAIT.

WAIT state:
- On alu_valid = 1: latch alu_result; rsp_err = 0; move to RESP.
- Otherwise, when the watchdog reaches TIMEOUT-1: rsp_data = 0; rsp_err = 1; move to RESP.
- If alu_valid and the timeout occur in the same cycle, alu_valid wins.

RESP state:
- rsp_valid = 1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready = 1.
- On handshake: RR pointer = (id+1) mod NUM_REQ.
- On handshake, the cool-down counter is loaded with THROTTLE_GAP if throttle = 1, otherwise 0. Move to IDLE.

Throttle and cool-down:
- The cool-down counter decrements every cycle while it is nonzero, whatever the throttle value.
- Raising throttle mid-operation does not abort the operation. It only affects the load at the RESP handshake.

Stale results:
- alu_valid seen in IDLE, ISSUE or RESP is ignored, including late results after a timeout.

Latency:
- Accept at cycle T; alu_start at T+1.
- If the ALU returns at T+1+k (k at least 1), rsp_valid rises at T+2+k.
- Minimum accept-to-accept spacing is 4 cycles.

Misc:
- busy = 1 in ISSUE, WAIT and RESP.
- Reset mid-operation immediately returns to reset values. No response is produced.

Optional Feature:
- Macro: SPU_SCHED_BINDU_PRIO_EN.
- With it: requester 0 has fixed top priority. If req_valid[0] = 1 it wins regardless of the RR pointer.
- Remaining requesters use RR, and the pointer updates only on grants to non-zero IDs.
- Without it: pure RR for all requesters.

Decomposition:
- Package spu_sched_pkg holds:
  - state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  - opcode width constant (4);
  - the $clog2-based ID-width function.
- Sub-module spu_rr_arbiter: combinational rotate, priority-encode and unrotate. Inputs are the request vector and the pointer; outputs are one-hot grant plus encoded ID. Instantiated once.

Test Plan:
- Single request: req_valid = 4'b0100, opcode 3, a = 7, b = 6. ALU returns 42 after 3 cycles, rsp_ready = 1. Expected: req_ready[2] at T; alu_start at T+1; rsp_valid at T+5; rsp_id = 2; rsp_data = 42; rsp_err = 0.
- Fairness: all 4 req_valid held high for 8 operations. Expected grant order 0,1,2,3,0,1,2,3.
- With SPU_SCHED_BINDU_PRIO_EN: the same stimulus yields order 0,0,0,… while req_valid[0] = 1.
- Timeout: ALU never responds. Expected: rsp_valid with rsp_err = 1 and rsp_data = 0 exactly TIMEOUT cycles after alu_start. A late alu_valid arriving in IDLE afterwards is ignored and busy stays 0.
- Throttle: throttle = 1 and two back-to-back requests. Expected: the second req_ready no earlier than THROTTLE_GAP = 8 cycles after the first RESP handshake. With throttle = 0, the gap is 0.
- Backpressure and reset: rsp_ready held low for 10 cycles. Expected: rsp_* stable and no new accept. Asserting rst_n = 0 while in WAIT clears all outputs within the same cycle; after release, the next grant goes to requester 0.
